// File: rtl/size_patch_arbiter.sv
// Round-robin arbiter that serialises multi-byte big-endian patch writes from
// several requesters onto a single byte-wide buffer write port.
module size_patch_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_val,
    input  logic [NUM_REQ*3-1:0]   req_bytes,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [7:0]             mem_data,
    input  logic                   mem_ready,
    output logic                   busy,
    output logic                   err_size
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       last_grant_q, last_grant_d;
    logic [1:0]          idx_q, idx_d;
    logic [2:0]          bytes_q, bytes_d;
    logic [31:0]         val_q, val_d;
    logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [7:0]          mem_data_q, mem_data_d;
    logic                busy_q, busy_d;
    logic                err_size_q, err_size_d;

    logic                found;
    logic [IW-1:0]       win;
    logic [IW-1:0]       cand;
    logic [2:0]          win_bytes;

    function automatic logic [7:0] sel_byte(input logic [31:0] v, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = v[7:0];
            2'd1:    b = v[15:8];
            2'd2:    b = v[23:16];
            default: b = v[31:24];
        endcase
        return b;
    endfunction

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        bytes_d      = bytes_q;
        val_d        = val_q;
        req_ack_d    = '0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        err_size_d   = err_size_q;
        found        = 1'b0;
        win          = '0;
        cand         = '0;

        // Search starts one past the last winner so every requester gets a turn.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_grant_q) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_bytes = req_bytes[3*win +: 3];

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ack_d[win] = 1'b1;
                    last_grant_d   = win;
                    if (win_bytes >= 3'd1 && win_bytes <= 3'd4) begin
                        state_d    = WRITE;
                        idx_d      = 2'd0;
                        bytes_d    = win_bytes;
                        val_d      = req_val[32*win +: 32];
                        mem_we_d   = 1'b1;
                        mem_addr_d = req_addr[32*win +: 32];
                        mem_data_d = sel_byte(req_val[32*win +: 32], 2'(win_bytes - 3'd1));
                    end else begin
                        err_size_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    if ({1'b0, idx_q} == bytes_q - 3'd1) begin
                        state_d    = IDLE;
                        mem_we_d   = 1'b0;
                        mem_addr_d = '0;
                        mem_data_d = '0;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        mem_addr_d = mem_addr_q + 32'd1;
                        mem_data_d = sel_byte(val_q, 2'(bytes_q - 3'd2 - {1'b0, idx_q}));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == WRITE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            idx_q        <= '0;
            bytes_q      <= '0;
            val_q        <= '0;
            req_ack_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            busy_q       <= 1'b0;
            err_size_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            bytes_q      <= bytes_d;
            val_q        <= val_d;
            req_ack_q    <= req_ack_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            busy_q       <= busy_d;
            err_size_q   <= err_size_d;
        end
    end

    assign req_ack  = req_ack_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign busy     = busy_q;
    assign err_size = err_size_q;

endmodule

// File: tb/tb_size_patch_arbiter.sv
// Directed self-checking bench for size_patch_arbiter; inputs change and
// outputs are sampled on the falling clock edge.
module tb_size_patch_arbiter;

    localparam int N = 4;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_val;
    logic [N*3-1:0]  req_bytes;
    logic [N-1:0]    req_ack;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [7:0]      mem_data;
    logic            mem_ready;
    logic            busy;
    logic            err_size;

    int checks;
    int failures;

    size_patch_arbiter #(.NUM_REQ(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_val   (req_val),
        .req_bytes (req_bytes),
        .req_ack   (req_ack),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err_size  (err_size)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] v, input logic [2:0] b);
        req_addr[32*p +: 32] = a;
        req_val[32*p +: 32]  = v;
        req_bytes[3*p +: 3]  = b;
        req_valid[p]         = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ack, input logic we,
                           input logic [31:0] addr, input logic [7:0] data);
        chk({tag, "_ack"},  32'(req_ack), 32'(ack));
        chk({tag, "_we"},   32'(mem_we), 32'(we));
        chk({tag, "_addr"}, mem_addr, addr);
        chk({tag, "_data"}, 32'(mem_data), 32'(data));
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while ((busy || mem_we) && c < 20) begin
            step();
            c++;
        end
        chk({tag, "_idle_timeout"}, 32'(busy || mem_we), 32'd0);
    endtask

    task automatic collect(input string tag, input int want, output int order[$]);
        order = {};
        for (int c = 0; c < 40 && order.size() < want; c++) begin
            step();
            chk({tag, "_onehot"}, 32'($onehot0(req_ack)), 32'd1);
            for (int p = 0; p < N; p++) begin
                if (req_ack[p]) begin
                    order.push_back(p);
                    req_valid[p] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int          order[$];
        int          we_cnt;
        logic [31:0] e_addr[8];
        logic [7:0]  e_data[8];
        logic        e_we[8];

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_val   = '0;
        req_bytes = '0;
        mem_ready = 1'b1;
        #12;
        chk_out("reset", 4'b0000, 1'b0, 32'h0, 8'h00);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err_size), 32'd0);
        step();
        reset = 1'b0;

        // Two-byte write from port 0
        set_req(0, 32'h100, 32'h0000_1234, 3'd2);
        step();
        chk_out("p0_b0", 4'b0001, 1'b1, 32'h100, 8'h12);
        chk("p0_busy1", 32'(busy), 32'd1);
        req_valid[0] = 1'b0;
        step();
        chk_out("p0_b1", 4'b0000, 1'b1, 32'h101, 8'h34);
        step();
        chk_out("p0_end", 4'b0000, 1'b0, 32'h0, 8'h00);
        chk("p0_busy0", 32'(busy), 32'd0);

        // Four-byte write from port 1
        set_req(1, 32'h8, 32'h0001_86A0, 3'd4);
        step();
        chk_out("p1_b0", 4'b0010, 1'b1, 32'h8, 8'h00);
        req_valid[1] = 1'b0;
        step();
        chk_out("p1_b1", 4'b0000, 1'b1, 32'h9, 8'h01);
        step();
        chk_out("p1_b2", 4'b0000, 1'b1, 32'hA, 8'h86);
        step();
        chk_out("p1_b3", 4'b0000, 1'b1, 32'hB, 8'hA0);
        step();
        chk_out("p1_end", 4'b0000, 1'b0, 32'h0, 8'h00);

        // Fresh reset, all four requesters at once
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int p = 0; p < N; p++) set_req(p, 32'h40 + 32'(p), 32'h10 + 32'(p), 3'd1);
        collect("rr4", 4, order);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr4_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFF, 32'(i));
        wait_idle("rr4");
        set_req(0, 32'h50, 32'h1, 3'd1);
        set_req(2, 32'h52, 32'h2, 3'd1);
        collect("rr2", 2, order);
        chk("rr2_first",  (order.size() > 0) ? 32'(order[0]) : 32'hFF, 32'd0);
        chk("rr2_second", (order.size() > 1) ? 32'(order[1]) : 32'hFF, 32'd2);
        wait_idle("rr2");

        // Backpressure: ready low for three cycles while the second byte is offered
        e_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e_addr = '{32'h200, 32'h201, 32'h201, 32'h201, 32'h201, 32'h202, 32'h203, 32'h0};
        e_data = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        we_cnt = 0;
        set_req(3, 32'h200, 32'hAABB_CCDD, 3'd4);
        for (int c = 0; c < 8; c++) begin
            step();
            chk_out($sformatf("bp_c%0d", c), (c == 0) ? 4'b1000 : 4'b0000, e_we[c], e_addr[c], e_data[c]);
            if (mem_we) we_cnt++;
            if (c == 0) req_valid[3] = 1'b0;
            if (c == 1) mem_ready = 1'b0;
            if (c == 4) mem_ready = 1'b1;
        end
        chk("bp_we_count", 32'(we_cnt), 32'd7);

        // Address wrap, upper value bits ignored
        set_req(0, 32'hFFFF_FFFF, 32'h1234_BEEF, 3'd2);
        step();
        chk_out("wrap_b0", 4'b0001, 1'b1, 32'hFFFF_FFFF, 8'hBE);
        req_valid[0] = 1'b0;
        step();
        chk_out("wrap_b1", 4'b0000, 1'b1, 32'h0, 8'hEF);
        step();
        chk_out("wrap_end", 4'b0000, 1'b0, 32'h0, 8'h00);

        // Illegal sizes are acked without writing and set the sticky error
        set_req(3, 32'h60, 32'hFF, 3'd0);
        step();
        chk_out("sz0", 4'b1000, 1'b0, 32'h0, 8'h00);
        chk("sz0_err", 32'(err_size), 32'd1);
        chk("sz0_busy", 32'(busy), 32'd0);
        req_valid[3] = 1'b0;
        set_req(2, 32'h61, 32'hFF, 3'd5);
        step();
        chk_out("sz5", 4'b0100, 1'b0, 32'h0, 8'h00);
        chk("sz5_err", 32'(err_size), 32'd1);
        req_valid[2] = 1'b0;
        set_req(1, 32'h70, 32'h5A, 3'd1);
        step();
        chk_out("post_err", 4'b0010, 1'b1, 32'h70, 8'h5A);
        chk("post_err_sticky", 32'(err_size), 32'd1);
        req_valid[1] = 1'b0;
        step();
        chk("post_err_sticky2", 32'(err_size), 32'd1);

        // Reset during a write
        set_req(1, 32'h300, 32'h1122_3344, 3'd4);
        step();
        chk_out("mid_b0", 4'b0010, 1'b1, 32'h300, 8'h11);
        req_valid[1] = 1'b0;
        step();
        chk_out("mid_b1", 4'b0000, 1'b1, 32'h301, 8'h22);
        #2 reset = 1'b1;
        #1;
        chk_out("mid_rst", 4'b0000, 1'b0, 32'h0, 8'h00);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err_size), 32'd0);
        step();
        step();
        reset = 1'b0;
        set_req(1, 32'h400, 32'h77, 3'd1);
        set_req(0, 32'h500, 32'h66, 3'd1);
        step();
        chk_out("post_rst_g0", 4'b0001, 1'b1, 32'h500, 8'h66);
        req_valid[0] = 1'b0;
        step();
        chk("post_rst_gap", 32'(req_ack), 32'd0);
        step();
        chk_out("post_rst_g1", 4'b0010, 1'b1, 32'h400, 8'h77);
        req_valid[1] = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
